// File: rtl/cp0_exc_unit_pkg.sv
// CP0 shared constants: exception codes, register numbers, field positions.
package cp0_exc_unit_pkg;

  localparam logic [4:0] EXCCODE_INT     = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL    = 5'd4;
  localparam logic [4:0] EXCCODE_ADES    = 5'd5;
  localparam logic [4:0] EXCCODE_SYSCALL = 5'd8;
  localparam logic [4:0] EXCCODE_RI      = 5'd10;
  localparam logic [4:0] EXCCODE_OV      = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_BD    = 31;

endpackage

// File: rtl/cp0_req_arb.sv
// Interrupt/exception arbitration: request, ExcCode select, EPC target.
module cp0_req_arb
  import cp0_exc_unit_pkg::*;
(
  input  logic        ie,
  input  logic        exl,
  input  logic [5:0]  im,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  exc_code,
  input  logic        bd_m,
  input  logic [31:0] pc_m,
  output logic        req,
  output logic [4:0]  code,
  output logic [31:0] epc_tgt
);

  logic int_req;
  logic exc_req;

  always_comb begin
    int_req = ie & ~exl & (|(hw_int & im));
    exc_req = ~exl & (exc_code != 5'd0);
    req     = int_req | exc_req;
    // interrupts win over a same-cycle synchronous exception
    code    = int_req ? EXCCODE_INT : exc_code;
    epc_tgt = bd_m ? (pc_m - 32'd4) : pc_m;
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception entry and eret restore.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_0800,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic [4:0]  arb_code;
  logic [31:0] arb_epc;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  cp0_req_arb u_arb (
    .ie       (ie_q),
    .exl      (exl_q),
    .im       (im_q),
    .hw_int   (hw_int),
    .exc_code (exc_code),
    .bd_m     (bd_m),
    .pc_m     (pc_m),
    .req      (req),
    .code     (arb_code),
    .epc_tgt  (arb_epc)
  );

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_int;
    exc_d = exc_q;
    epc_d = epc_q;
    if (!reset) begin
      im_d  = '0;
      exl_d = 1'b0;
      ie_d  = 1'b0;
      bd_d  = 1'b0;
      ip_d  = '0;
      exc_d = '0;
      epc_d = '0;
    end else if (req) begin
      exl_d = 1'b1;
      exc_d = arb_code;
      bd_d  = bd_m;
      epc_d = arb_epc;
    end else begin
      if (eret) exl_d = 1'b0;
      // an SR write lands after eret, so it owns EXL
      if (we) begin
        case (addr)
          CP0_SR: begin
            im_d  = wdata[SR_IM_LO +: 6];
            exl_d = wdata[SR_EXL];
            ie_d  = wdata[SR_IE];
          end
          CP0_EPC: epc_d = wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    im_q  <= im_d;
    exl_q <= exl_d;
    ie_q  <= ie_d;
    bd_q  <= bd_d;
    ip_q  <= ip_d;
    exc_q <= exc_d;
    epc_q <= epc_d;
  end

  always_comb begin
    sr_rd = '0;
    sr_rd[SR_IM_LO +: 6] = im_q;
    sr_rd[SR_EXL]        = exl_q;
    sr_rd[SR_IE]         = ie_q;
    cause_rd = '0;
    cause_rd[CAUSE_BD]            = bd_q;
    cause_rd[CAUSE_IP_LO +: 6]    = ip_q;
    cause_rd[CAUSE_EXC_LO +: 5]   = exc_q;
    case (addr)
      CP0_SR:    rdata = sr_rd;
      CP0_CAUSE: rdata = cause_rd;
      CP0_EPC:   rdata = epc_q;
      CP0_PRID:  rdata = PRID_VAL;
      default:   rdata = '0;
    endcase
  end

  assign handler_pc = HANDLER_PC;
  assign epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit with hand-computed expectations.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int n_chk;
  int n_err;

  cp0_exc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .pc_m       (pc_m),
    .bd_m       (bd_m),
    .exc_code   (exc_code),
    .hw_int     (hw_int),
    .eret       (eret),
    .req        (req),
    .handler_pc (handler_pc),
    .epc_out    (epc_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a,
                    input logic [31:0] exp,
                    input string tag);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic req_is(input logic exp, input string tag);
    #1;
    check(tag, {31'd0, req}, {31'd0, exp});
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    pc_m = '0;
    bd_m = 1'b0;
    exc_code = '0;
    hw_int = '0;
    eret = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd15, 32'h0000_0800, "prid");
    rd(5'd3, 32'h0, "unimpl");
    check("handler_pc", handler_pc, 32'h0000_4180);
    req_is(1'b0, "rst_req");

    mtc0(5'd12, 32'hFFFF_FC03);
    rd(5'd12, 32'h0000_FC03, "sr_wr");
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0, "cause_wr_ign");
    mtc0(5'd12, 32'h0);
    rd(5'd12, 32'h0, "sr_clr");

    exc_code = 5'd12;
    pc_m = 32'h0000_3010;
    bd_m = 1'b0;
    req_is(1'b1, "ov_req");
    tick();
    exc_code = 5'd0;
    rd(5'd13, 32'h0000_0030, "ov_cause");
    rd(5'd14, 32'h0000_3010, "ov_epc");
    rd(5'd12, 32'h0000_0002, "ov_exl");
    check("ov_epc_out", epc_out, 32'h0000_3010);
    exc_code = 5'd4;
    req_is(1'b0, "nested_mask");
    exc_code = 5'd0;

    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, 32'h0, "eret_exl");
    check("eret_epc", epc_out, 32'h0000_3010);

    exc_code = 5'd5;
    bd_m = 1'b1;
    pc_m = 32'h0000_3024;
    we = 1'b1;
    addr = 5'd14;
    wdata = 32'hDEAD_BEEF;
    req_is(1'b1, "ades_req");
    tick();
    we = 1'b0;
    exc_code = 5'd0;
    bd_m = 1'b0;
    rd(5'd14, 32'h0000_3020, "bd_epc");
    rd(5'd13, 32'h8000_0014, "bd_cause");
    eret = 1'b1;
    tick();
    eret = 1'b0;

    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, 32'h0000_0401, "sr_ie");
    hw_int = 6'b000001;
    exc_code = 5'd10;
    req_is(1'b1, "int_req");
    rd(5'd13, 32'h8000_0014, "ip_lag");
    tick();
    exc_code = 5'd0;
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd12, 32'h0000_0403, "int_sr");

    eret = 1'b1;
    we = 1'b1;
    addr = 5'd12;
    wdata = 32'h0000_0003;
    tick();
    eret = 1'b0;
    we = 1'b0;
    rd(5'd12, 32'h0000_0003, "eret_mtc0");
    mtc0(5'd12, 32'h0000_0001);
    rd(5'd12, 32'h0000_0001, "im_zero");
    hw_int = 6'h3F;
    req_is(1'b0, "im_mask");

    exc_code = 5'd8;
    pc_m = 32'h0000_5000;
    req_is(1'b1, "sys_req");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exc_code = 5'd0;
    hw_int = '0;
    rd(5'd12, 32'h0, "rst2_sr");
    rd(5'd13, 32'h0, "rst2_cause");
    rd(5'd14, 32'h0, "rst2_epc");
    check("rst2_epc_out", epc_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
